// File: rtl/rv32i_pkg.sv
// rv32i_pkg: opcodes, PC-select encodings, sequencer states and instruction classes
// shared by the rv32i control and datapath blocks.
package rv32i_pkg;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JAL    = 2'b10;
    localparam logic [1:0] PC_SEL_JALR   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
    } seq_state_e;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_LOAD, CLS_STORE, CLS_SYSTEM, CLS_ILLEGAL
    } instr_class_e;

    function automatic logic [1:0] pc_sel_of(instr_class_e c);
        return c == CLS_BRANCH ? PC_SEL_BRANCH :
               c == CLS_JAL    ? PC_SEL_JAL    :
               c == CLS_JALR   ? PC_SEL_JALR   : PC_SEL_PLUS4;
    endfunction
endpackage

// File: rtl/instr_class_dec.sv
// instr_class_dec: combinational opcode-to-instruction-class decoder.
module instr_class_dec
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] cls
);
    always_comb begin
        case (opcode)
            OP_BRANCH:                          cls = CLS_BRANCH;
            OP_JAL:                             cls = CLS_JAL;
            OP_JALR:                            cls = CLS_JALR;
            OP_LOAD:                            cls = CLS_LOAD;
            OP_STORE:                           cls = CLS_STORE;
            OP_OP, OP_OP_IMM, OP_LUI, OP_AUIPC: cls = CLS_ALU;
            OP_SYSTEM:                          cls = CLS_SYSTEM;
            default:                            cls = CLS_ILLEGAL;
        endcase
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch/decode/exec/mem/wb control for the rv32i core.
// Define PC_SEQ_MISALIGN_TRAP_EN to halt on misaligned control-transfer targets.
module pc_sequencer
    import rv32i_pkg::*;
#(
    parameter int IMEM_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic [31:0] pc_next,
    input  logic        s_branch,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic [1:0]  pc_sel,
    output logic        pc_en,
    output logic        rf_we,
    output logic        halt,
    output logic        illegal,
    output logic        misalign
);
    seq_state_e   state_q, state_d;
    logic [31:0]  ir_q, ir_d, wait_q, wait_d;
    logic         illegal_q, illegal_d, misalign_q, misalign_d;
    logic [2:0]   cls_raw;
    instr_class_e cls;
    logic         trap;

    instr_class_dec u_dec (.opcode(ir_q[6:0]), .cls(cls_raw));
    assign cls = instr_class_e'(cls_raw);

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    // a not-taken branch falls through to pc+4, so only taken branches can trap
    assign trap = (cls == CLS_BRANCH ? s_branch : (cls == CLS_JAL || cls == CLS_JALR))
                  && pc_next[1:0] != 2'b00;
`else
    logic unused_inputs;
    assign unused_inputs = s_branch ^ (^pc_next);
    assign trap = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        wait_d     = '0;
        illegal_d  = illegal_q;
        misalign_d = misalign_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        pc_en      = 1'b0;
        rf_we      = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end else if (IMEM_TIMEOUT > 0 && wait_q == 32'(IMEM_TIMEOUT - 1)) begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            ST_DECODE: begin
                state_d   = (cls == CLS_SYSTEM || cls == CLS_ILLEGAL) ? ST_HALT : ST_EXEC;
                illegal_d = illegal_q | (cls == CLS_ILLEGAL);
            end
            ST_EXEC: begin
                if (cls == CLS_LOAD || cls == CLS_STORE) begin
                    state_d = ST_MEM;
                end else if (trap) begin
                    state_d    = ST_HALT;
                    misalign_d = 1'b1;
                end else begin
                    pc_en   = 1'b1;
                    rf_we   = cls != CLS_BRANCH;
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = cls == CLS_STORE;
                state_d  = dmem_ack ? ST_WB : ST_MEM;
            end
            ST_WB: begin
                pc_en   = 1'b1;
                rf_we   = cls == CLS_LOAD;
                state_d = ST_FETCH;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ir_q       <= '0;
            wait_q     <= '0;
            illegal_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            wait_q     <= wait_d;
            illegal_q  <= illegal_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_sel    = (state_q inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) ? pc_sel_of(cls) : PC_SEL_PLUS4;
    assign imem_addr = pc;
    assign instr     = ir_q;
    assign halt      = state_q == ST_HALT;
    assign illegal   = illegal_q;
    assign misalign  = misalign_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized self-checking bench; expected per-cycle outputs come from
// a timeline model of each instruction (fetch waits, decode, exec, mem waits, wb).
module tb_pc_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] pc = '0, pc_next = '0, imem_rdata = '0;
    logic        s_branch = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
    logic [31:0] imem_addr, instr;
    logic        imem_req, dmem_req, dmem_we, pc_en, rf_we, halt, illegal, misalign;
    logic [1:0]  pc_sel;

    int checks = 0, errors = 0;
    logic [10:0] expq[$], obsq[$];
    logic [31:0] p_ins, p_pn;
    int          p_fw, p_mw;
    bit          p_sb, halts;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .pc_next(pc_next), .s_branch(s_branch),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .pc_sel(pc_sel), .pc_en(pc_en), .rf_we(rf_we), .halt(halt), .illegal(illegal),
        .misalign(misalign)
    );

    // 0 alu, 1 branch, 2 jal, 3 jalr, 4 load, 5 store, 6 system, 7 illegal
    function automatic int cls_of(logic [6:0] op);
        case (op)
            7'b1100011: return 1;
            7'b1101111: return 2;
            7'b1100111: return 3;
            7'b0000011: return 4;
            7'b0100011: return 5;
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: return 0;
            7'b1110011: return 6;
            default: return 7;
        endcase
    endfunction

    function automatic logic [1:0] sel_of(int c);
        return c == 1 ? 2'b01 : c == 2 ? 2'b10 : c == 3 ? 2'b11 : 2'b00;
    endfunction

    function automatic logic [10:0] vec(bit ir, bit dr, bit dw, bit pe, bit rw,
                                        logic [1:0] ps, bit h, bit il, bit mi);
        return {1'b1, ir, dr, dw, pe, rw, ps, h, il, mi};
    endfunction

    function automatic logic [10:0] sample();
        return {imem_addr === pc, imem_req, dmem_req, dmem_we, pc_en, rf_we, pc_sel, halt, illegal, misalign};
    endfunction

    task automatic plan(input logic [31:0] ins, input int fw, input int mw, input bit sb, input logic [31:0] pn);
        p_ins = ins; p_fw = fw; p_mw = mw; p_sb = sb; p_pn = pn;
    endtask

    task automatic build_exp();
        int  c;
        bit  trap;
        c    = cls_of(p_ins[6:0]);
        trap = TRAP_EN && (c == 1 ? p_sb : (c == 2 || c == 3)) && p_pn[1:0] != 2'b00;
        expq.delete();
        halts = 1'b0;
        for (int k = 0; k <= p_fw; k++) expq.push_back(vec(1, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        expq.push_back(vec(0, 0, 0, 0, 0, sel_of(c), 0, 0, 0));
        if (c >= 6) begin
            halts = 1'b1;
            repeat (3) expq.push_back(vec(0, 0, 0, 0, 0, 2'b00, 1, c == 7, 0));
        end else if (c < 4) begin
            expq.push_back(vec(0, 0, 0, !trap, !trap && c != 1, sel_of(c), 0, 0, 0));
            if (trap) begin
                halts = 1'b1;
                repeat (3) expq.push_back(vec(0, 0, 0, 0, 0, 2'b00, 1, 0, 1));
            end
        end else begin
            expq.push_back(vec(0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
            for (int k = 0; k <= p_mw; k++) expq.push_back(vec(0, 1, c == 5, 0, 0, 2'b00, 0, 0, 0));
            expq.push_back(vec(0, 0, 0, 1, c == 4, 2'b00, 0, 0, 0));
        end
    endtask

    // drives one planned instruction for n cycles, with spurious acks outside their windows
    task automatic drive_plan(input int n);
        int c, lo, hi;
        c  = cls_of(p_ins[6:0]);
        lo = p_fw + 3;
        hi = lo + p_mw;
        obsq.delete();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0) pc = $urandom & 32'hFFFF_FFFC;
            pc_next    = p_pn;
            s_branch   = p_sb;
            imem_ack   = (k == p_fw) || (k > p_fw && $urandom_range(0, 1) == 1);
            imem_rdata = (k == p_fw) ? p_ins : $urandom;
            dmem_ack   = ((c == 4 || c == 5) && k >= lo && k <= hi) ? (k == hi) : ($urandom_range(0, 1) == 1);
            #1;
            obsq.push_back(sample());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1; imem_rdata = 32'h00500093; pc = 32'h100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sample() !== vec(0, 0, 0, 0, 0, 2'b00, 0, 0, 0)) begin
            errors++; $display("FAIL reset_out got %b exp %b", sample(), vec(0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        end
        checks++;
        if (instr !== 32'h0) begin errors++; $display("FAIL reset_ir got %h exp 0", instr); end
        @(posedge clk);
        #1 rst_n = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (sample() !== vec(0, 0, 0, 0, 0, 2'b00, 0, 0, 0)) begin
            errors++; $display("FAIL idle_out got %b exp %b", sample(), vec(0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        end
        checks++;
        if (instr !== 32'h0) begin errors++; $display("FAIL idle_ir got %h exp 0", instr); end
    endtask

    task automatic test_alu();
        plan(32'h00500093, 0, 0, 1'b0, 32'h0000_0104);
        build_exp();
        drive_plan(expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            checks++;
            if (obsq[i] !== expq[i]) begin errors++; $display("FAIL alu cyc%0d got %b exp %b", i, obsq[i], expq[i]); end
        end
        checks++;
        if (instr !== 32'h00500093) begin errors++; $display("FAIL alu_ir got %h exp 00500093", instr); end
    endtask

    task automatic test_branch();
        plan(32'h00208463, 2, 0, 1'b1, 32'h0000_0208);
        build_exp();
        drive_plan(expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            checks++;
            if (obsq[i] !== expq[i]) begin errors++; $display("FAIL branch cyc%0d got %b exp %b", i, obsq[i], expq[i]); end
        end
    endtask

    task automatic test_mem();
        for (int t = 0; t < 2; t++) begin
            plan(t == 0 ? 32'h0000A103 : 32'h0020A023, t, 3 - t, 1'b0, 32'h0000_0300);
            build_exp();
            drive_plan(expq.size());
            for (int i = 0; i < expq.size(); i++) begin
                checks++;
                if (obsq[i] !== expq[i]) begin errors++; $display("FAIL mem%0d cyc%0d got %b exp %b", t, i, obsq[i], expq[i]); end
            end
        end
    endtask

    task automatic test_halt();
        for (int t = 0; t < 2; t++) begin
            plan(t == 0 ? 32'h0000007F : 32'h00000073, t, 0, 1'b0, 32'h0);
            build_exp();
            drive_plan(expq.size());
            for (int i = 0; i < expq.size(); i++) begin
                checks++;
                if (obsq[i] !== expq[i]) begin errors++; $display("FAIL halt%0d cyc%0d got %b exp %b", t, i, obsq[i], expq[i]); end
            end
            do_reset();
        end
    endtask

    task automatic test_misalign();
        for (int t = 0; t < 2; t++) begin
            plan(t == 0 ? 32'h000080E7 : 32'h00208463, 0, 0, 1'b0, t == 0 ? 32'h102 : 32'h202);
            build_exp();
            drive_plan(expq.size());
            for (int i = 0; i < expq.size(); i++) begin
                checks++;
                if (obsq[i] !== expq[i]) begin errors++; $display("FAIL misalign%0d cyc%0d got %b exp %b", t, i, obsq[i], expq[i]); end
            end
            if (halts) do_reset();
        end
    endtask

    task automatic test_reset_mid_mem();
        plan(32'h0000A103, 0, 6, 1'b0, 32'h0);
        build_exp();
        drive_plan(5);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obsq[i] !== expq[i]) begin errors++; $display("FAIL midmem cyc%0d got %b exp %b", i, obsq[i], expq[i]); end
        end
        #2 rst_n = 1'b0; dmem_ack = 1'b0;
        #1;
        checks++;
        if (sample() !== vec(0, 0, 0, 0, 0, 2'b00, 0, 0, 0)) begin
            errors++; $display("FAIL midmem_async got %b exp %b", sample(), vec(0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b1;
        #1;
        checks++;
        if (sample() !== vec(0, 0, 0, 0, 0, 2'b00, 0, 0, 0)) begin
            errors++; $display("FAIL midmem_idle got %b exp %b", sample(), vec(0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        end
        plan(32'h00000013, 1, 0, 1'b0, 32'h4);
        build_exp();
        drive_plan(expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            checks++;
            if (obsq[i] !== expq[i]) begin errors++; $display("FAIL resume cyc%0d got %b exp %b", i, obsq[i], expq[i]); end
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [11] = '{7'h63, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h33, 7'h13, 7'h37, 7'h17, 7'h73, 7'h33};
        logic [31:0] ins, pn;
        int          idx;
        for (int n = 0; n < 60; n++) begin
            idx     = $urandom_range(0, 11);
            ins     = $urandom;
            ins[6:0] = (idx == 11) ? 7'($urandom) : ops[idx];
            pn      = $urandom;
            if ($urandom_range(0, 3) != 0) pn[1:0] = 2'b00;
            plan(ins, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) == 1, pn);
            build_exp();
            drive_plan(expq.size());
            for (int i = 0; i < expq.size(); i++) begin
                checks++;
                if (obsq[i] !== expq[i]) begin
                    errors++; $display("FAIL rand%0d ins %h cyc%0d got %b exp %b", n, ins, i, obsq[i], expq[i]);
                end
            end
            if (halts) do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_mem();
        test_halt();
        test_misalign();
        test_reset_mid_mem();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
